// File: rtl/zion_shared_reg_arbiter_if.sv
// Request/response bundle between the configuration masters and the shared
// register arbiter. Requester k owns bit k of each request vector and the
// WIDTH-bit slice [k*WIDTH +: WIDTH] of iReqDat.
interface zion_shared_reg_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       iReqVld;
  logic [NUM_REQ-1:0]       iReqClr;
  logic [NUM_REQ-1:0]       iReqLock;
  logic [NUM_REQ*WIDTH-1:0] iReqDat;
  logic [NUM_REQ-1:0]       oReqRdy;
  logic [WIDTH-1:0]         oDat;
  logic                     oUpd;
  logic [IW-1:0]            oOwner;
  logic                     oLocked;

  modport master (
    output iReqVld, iReqClr, iReqLock, iReqDat,
    input  oReqRdy, oDat, oUpd, oOwner, oLocked
  );

  modport slave (
    input  iReqVld, iReqClr, iReqLock, iReqDat,
    output oReqRdy, oDat, oUpd, oOwner, oLocked
  );
endinterface

// File: rtl/zion_shared_reg_arbiter.sv
// Round-robin arbiter in front of one shared clear/enable register.
// Optional feature macro: ZION_SHREG_LOCK_EN -- when defined, a transfer with
// iReqLock set gives that requester exclusive ownership until it transfers
// again with iReqLock clear. Without it the FSM never leaves IDLE.
module zion_shared_reg_arbiter #(
  parameter int               NUM_REQ  = 4,
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] INI_DATA = WIDTH'(1)
) (
  input logic                     clk,
  input logic                     rst,
  zion_shared_reg_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t                         state, stateNxt;
  logic   [IW-1:0]                ptr;
  logic   [IW-1:0]                ownerQ;
  logic   [WIDTH-1:0]             datQ;
  logic                           updQ;
  logic                           lockedC;
  logic   [NUM_REQ-1:0][WIDTH-1:0] reqDat;
  logic   [IW-1:0]                gntIdx;
  logic                           gntHit;
  logic   [NUM_REQ-1:0]           rdy;
  logic                           xfer;
  int                             idx;

  assign reqDat = bus.iReqDat;

  // Grant select: in OWN only the owner may win; otherwise the first valid
  // requester at or after ptr. Scanning offsets high-to-low lets the lowest
  // offset overwrite, giving the round-robin priority without a break.
  always_comb begin
    gntIdx = '0;
    gntHit = 1'b0;
    idx    = 0;
    if (state == OWN) begin
      gntIdx = ownerQ;
      gntHit = bus.iReqVld[ownerQ];
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        idx = int'(ptr) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (bus.iReqVld[idx]) begin
          gntIdx = IW'(idx);
          gntHit = 1'b1;
        end
      end
    end
  end

  // One-hot ready; forced low while reset is asserted so nothing handshakes.
  always_comb begin
    rdy = '0;
    if (rst && gntHit) rdy[gntIdx] = 1'b1;
  end

  assign xfer        = rst && gntHit;
  assign bus.oReqRdy = rdy;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= stateNxt;
  end

`ifdef ZION_SHREG_LOCK_EN
  // FSM next state: lock on a locking transfer, release when the owner
  // transfers without lock.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (xfer && bus.iReqLock[gntIdx])  stateNxt = OWN;
      OWN:     if (xfer && !bus.iReqLock[gntIdx]) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // FSM output: lock flag is the registered state itself.
  always_comb lockedC = (state == OWN);
`else
  logic unusedLock;
  assign unusedLock = ^bus.iReqLock;

  // FSM next state: no lock support, stay in IDLE.
  always_comb stateNxt = IDLE;

  // FSM output: never locked.
  always_comb lockedC = 1'b0;
`endif

  // Shared register, update pulse, owner and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      datQ   <= INI_DATA;
      updQ   <= 1'b0;
      ownerQ <= '0;
      ptr    <= '0;
    end else begin
      updQ <= xfer;
      if (xfer) begin
        datQ   <= bus.iReqClr[gntIdx] ? INI_DATA : reqDat[gntIdx];
        ownerQ <= gntIdx;
        ptr    <= (int'(gntIdx) == NUM_REQ - 1) ? '0 : gntIdx + 1'b1;
      end
    end
  end

  assign bus.oDat    = datQ;
  assign bus.oUpd    = updQ;
  assign bus.oOwner  = ownerQ;
  assign bus.oLocked = lockedC;
endmodule

// File: tb/tb_zion_shared_reg_arbiter.sv
// Directed + randomized bench with a behavioural model of the shared register.
module tb_zion_shared_reg_arbiter;
  localparam int N = 4;
  localparam int W = 32;
`ifdef ZION_SHREG_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zion_shared_reg_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus();

  zion_shared_reg_arbiter #(.NUM_REQ(N), .WIDTH(W), .INI_DATA(32'h1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mPtr    = 0;
  logic [31:0] mDat    = 32'h1;
  logic        mUpd    = 1'b0;
  int          mOwner  = 0;
  logic        mLocked = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which requester the rules say wins this cycle, -1 for none.
  function automatic int modelGrant(input logic [3:0] v);
    if (mLocked) return v[mOwner] ? mOwner : -1;
    for (int i = 0; i < N; i++)
      if (v[(mPtr + i) % N]) return (mPtr + i) % N;
    return -1;
  endfunction

  // One clock of stimulus; starts and ends just after a falling edge.
  task automatic step(input logic r, input logic [3:0] v, input logic [3:0] c,
                      input logic [3:0] l, input logic [127:0] d);
    int g;
    logic [3:0] expRdy;
    rst          = r;
    bus.iReqVld  = v;
    bus.iReqClr  = c;
    bus.iReqLock = l;
    bus.iReqDat  = d;
    #1;
    g = r ? modelGrant(v) : -1;
    expRdy = 4'b0;
    if (g >= 0) expRdy[g] = 1'b1;
    chk("rdy", 128'(bus.oReqRdy), 128'(expRdy));
    @(posedge clk);
    if (!r) begin
      mDat = 32'h1; mPtr = 0; mOwner = 0; mLocked = 1'b0; mUpd = 1'b0;
    end else if (g >= 0) begin
      mUpd   = 1'b1;
      mDat   = c[g] ? 32'h1 : d[g*W +: W];
      mPtr   = (g + 1) % N;
      if (LOCK_EN) begin
        if (!mLocked && l[g])      mLocked = 1'b1;
        else if (mLocked && !l[g]) mLocked = 1'b0;
      end
      mOwner = g;
    end else begin
      mUpd = 1'b0;
    end
    @(negedge clk);
    chk("dat",    128'(bus.oDat),    128'(mDat));
    chk("upd",    128'(bus.oUpd),    128'(mUpd));
    chk("owner",  128'(bus.oOwner),  128'(mOwner));
    chk("locked", 128'(bus.oLocked), 128'(mLocked));
  endtask

  logic [127:0] dd;
  logic [127:0] dRnd;

  initial begin
    dd = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    rst = 1'b0;
    bus.iReqVld = '0; bus.iReqClr = '0; bus.iReqLock = '0; bus.iReqDat = '0;
    @(negedge clk);

    // Reset held two cycles with everybody requesting.
    step(1'b0, 4'b1111, 4'b0, 4'b0, dd);
    step(1'b0, 4'b1111, 4'b0, 4'b0, dd);
    chk("rst_dat", 128'(bus.oDat), 128'(32'h1));

    // Fairness: grants 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b1111, 4'b0, 4'b0, dd);
      chk("fair_owner", 128'(bus.oOwner), 128'(i % N));
    end

    // Park ptr at 3, then 0101 -> 0, 2, 0.
    step(1'b1, 4'b0100, 4'b0, 4'b0, dd);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0101, 4'b0, 4'b0, dd);
    chk("wrap_owner", 128'(bus.oOwner), 128'(0));

    // Write then clear, then a clear of an already-initial value.
    step(1'b1, 4'b0010, 4'b0, 4'b0, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0});
    chk("clr_wr", 128'(bus.oDat), 128'(32'hDEAD_BEEF));
    step(1'b1, 4'b0100, 4'b0100, 4'b0, dd);
    chk("clr_clr", 128'(bus.oDat), 128'(32'h1));
    step(1'b1, 4'b1000, 4'b1000, 4'b0, dd);
    chk("clr_again_upd", 128'(bus.oUpd), 128'(1));
    step(1'b1, 4'b0000, 4'b0, 4'b0, dd);

    // Lock by 2: owner absent (stall), owner present, then release.
    step(1'b1, 4'b0100, 4'b0, 4'b0100, dd);
    step(1'b1, 4'b1011, 4'b0, 4'b0, dd);
    step(1'b1, 4'b1011, 4'b0, 4'b0, dd);
    step(1'b1, 4'b1111, 4'b0, 4'b0100, dd);
    step(1'b1, 4'b0100, 4'b0, 4'b0, dd);
    step(1'b1, 4'b1111, 4'b0, 4'b0, dd);

    // Reset while owned by requester 1.
    step(1'b1, 4'b0010, 4'b0, 4'b0010, dd);
    step(1'b0, 4'b0010, 4'b0, 4'b0, dd);
    chk("rstlock_locked", 128'(bus.oLocked), 128'(0));
    step(1'b1, 4'b1111, 4'b0, 4'b0, dd);
    chk("rstlock_ptr0", 128'(bus.oOwner), 128'(0));

    // Randomized traffic with occasional lock and rare reset.
    for (int i = 0; i < 300; i++) begin
      dRnd = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 49) != 0), 4'($urandom), 4'($urandom) & 4'($urandom),
           ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0, dRnd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
